mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin N-core memory request arbiter with response steering
// Tracks per-core outstanding requests and flags responses to cores with nothing in flight.
module mem_port_arbiter #(
  parameter int NUM_CORE        = 4,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CORE-1:0]                 core_rq_vld,
  input  logic [3*NUM_CORE-1:0]               core_rq_cmd,
  input  logic [48*NUM_CORE-1:0]              core_rq_vadr,
  input  logic [64*NUM_CORE-1:0]              core_rq_data,
  input  logic [MC_RTNCTL_WIDTH*NUM_CORE-1:0] core_rq_rtnctl,
  output logic [NUM_CORE-1:0]                 core_rq_gnt,
  output logic                                mc_rq_vld,
  output logic [2:0]                          mc_rq_cmd,
  output logic [47:0]                         mc_rq_vadr,
  output logic [63:0]                         mc_rq_data,
  output logic [MC_RTNCTL_WIDTH-1:0]          mc_rq_rtnctl,
  input  logic                                mc_rq_stall,
  input  logic                                mc_rs_vld,
  input  logic [MC_RTNCTL_WIDTH-1:0]          mc_rs_rtnctl,
  input  logic [63:0]                         mc_rs_data,
  output logic                                mc_rs_stall,
  output logic [NUM_CORE-1:0]                 core_rs_vld,
  output logic [MC_RTNCTL_WIDTH-1:0]          core_rs_rtnctl,
  output logic [63:0]                         core_rs_data,
  input  logic [NUM_CORE-1:0]                 core_rs_stall,
  output logic                                idle,
  output logic                                rs_err
);

  localparam int CID_W = $clog2(NUM_CORE);
  localparam int RW    = MC_RTNCTL_WIDTH;

  logic [3:0]          r_outst [NUM_CORE];
  logic [CID_W-1:0]    r_rr_ptr;
  logic                r_rs_err;
  logic                r_mc_vld;
  logic [2:0]          r_mc_cmd;
  logic [47:0]         r_mc_vadr;
  logic [63:0]         r_mc_data;
  logic [RW-1:0]       r_mc_rtnctl;

  logic [NUM_CORE-1:0] w_elig;
  logic [NUM_CORE-1:0] w_dec;
  logic [NUM_CORE-1:0] w_dec_zero;
  logic                w_all_zero;
  logic                w_can_load;
  logic                w_gnt_any;
  logic                w_grant;
  logic [CID_W-1:0]    w_gnt_idx;
  logic [CID_W-1:0]    w_cand;
  logic [CID_W-1:0]    w_rs_tgt;
  logic                w_rs_acc;

  always_comb begin
    w_all_zero = 1'b1;
    for (int i = 0; i < NUM_CORE; i++) begin
      w_elig[i]     = core_rq_vld[i] && (r_outst[i] < 4'(MAX_OUTSTANDING));
      w_dec_zero[i] = w_dec[i] && (r_outst[i] == 4'd0);
      if (r_outst[i] != 4'd0) w_all_zero = 1'b0;
    end
  end

  // Index arithmetic wraps naturally because NUM_CORE is a power of two.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_CORE; k++) begin
      w_cand = r_rr_ptr + CID_W'(k);
      if (!w_gnt_any && w_elig[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_can_load  = ~r_mc_vld | ~mc_rq_stall;
  assign w_grant     = w_gnt_any & w_can_load & ~reset;
  assign core_rq_gnt = {NUM_CORE{w_grant}} & (NUM_CORE'(1) << w_gnt_idx);

  assign w_rs_tgt       = mc_rs_rtnctl[RW-1 -: CID_W];
  assign core_rs_vld    = {NUM_CORE{mc_rs_vld}} & (NUM_CORE'(1) << w_rs_tgt);
  assign mc_rs_stall    = mc_rs_vld & core_rs_stall[w_rs_tgt];
  assign w_rs_acc       = mc_rs_vld & ~mc_rs_stall;
  assign w_dec          = {NUM_CORE{w_rs_acc}} & core_rs_vld;
  assign core_rs_rtnctl = mc_rs_rtnctl;
  assign core_rs_data   = mc_rs_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORE; i++) r_outst[i] <= 4'd0;
      r_rr_ptr <= '0;
      r_rs_err <= 1'b0;
    end else begin
      // A response to an empty counter is an error; the counter saturates at zero.
      for (int i = 0; i < NUM_CORE; i++) begin
        if (core_rq_gnt[i] && !w_dec[i])
          r_outst[i] <= r_outst[i] + 4'd1;
        else if (w_dec[i] && !core_rq_gnt[i] && r_outst[i] != 4'd0)
          r_outst[i] <= r_outst[i] - 4'd1;
      end
      if (|w_dec_zero) r_rs_err <= 1'b1;
      if (w_grant)     r_rr_ptr <= w_gnt_idx + CID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mc_vld    <= 1'b0;
      r_mc_cmd    <= '0;
      r_mc_vadr   <= '0;
      r_mc_data   <= '0;
      r_mc_rtnctl <= '0;
    end else if (w_grant) begin
      r_mc_vld    <= 1'b1;
      r_mc_cmd    <= core_rq_cmd[int'(w_gnt_idx)*3 +: 3];
      r_mc_vadr   <= core_rq_vadr[int'(w_gnt_idx)*48 +: 48];
      r_mc_data   <= core_rq_data[int'(w_gnt_idx)*64 +: 64];
      r_mc_rtnctl <= {w_gnt_idx, core_rq_rtnctl[int'(w_gnt_idx)*RW +: RW-CID_W]};
    end else if (r_mc_vld && !mc_rq_stall) begin
      r_mc_vld <= 1'b0;
    end
  end

  assign mc_rq_vld    = r_mc_vld;
  assign mc_rq_cmd    = r_mc_cmd;
  assign mc_rq_vadr   = r_mc_vadr;
  assign mc_rq_data   = r_mc_data;
  assign mc_rq_rtnctl = r_mc_rtnctl;
  assign idle         = w_all_zero & ~r_mc_vld;
  assign rs_err       = r_rs_err;

endmodule
